cva6_pma_table: RTL and testbench
=================================

# cva6_pma_table

Runtime-programmable physical-memory-attribute table for the CVA6 core. It replaces the compile-time execute, cached, shared and non-idempotent region lists with a parametrised array of address rules, reset to build-time values and reprogrammable through a register port. It answers pipelined address lookups from the fetch and LSU paths with a registered attribute vector.

## Interface
- NrRules, 8: number of rule slots, 1..16
- AddrWidth, 64: physical address width
- RstBase, all 0: per-rule reset base, NrRules×AddrWidth
- RstLength, all 0: per-rule reset length, NrRules×AddrWidth
- RstAttr, all 0: per-rule reset attributes, NrRules×8
- IdxW, $clog2(NrRules) (min 1): rule index width
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- lkp_valid_i  in  1  lookup request
- lkp_ready_o  out  1  lookup accepted
- lkp_addr_i  in  AddrWidth  address to classify
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  result consumed
- rsp_attr_o  out  4  {non_idempotent, shared, cached, exec}
- rsp_hit_o  out  1  some rule matched
- rsp_idx_o  out  IdxW  matching rule index
- cfg_valid_i  in  1  config access
- cfg_we_i  in  1  1 write, 0 read
- cfg_idx_i  in  4  rule index
- cfg_field_i  in  2  0 base, 1 length, 2 attr, 3 reserved
- cfg_wdata_i  in  AddrWidth  write data
- cfg_rvalid_o  out  1  access response
- cfg_rdata_o  out  AddrWidth  read data
- cfg_err_o  out  1  access rejected
- pma_changed_o  out  1  one-cycle pulse after a committed write (TLB/cache-policy flush)

## Operation
- Rule i matches when length_i ≠ 0 and base_i ≤ addr < base_i + length_i. The sum is computed at AddrWidth+1 bits; a carry means "extends to top of address space", never a wrap.
- Priority: lowest matching index wins. No match gives hit=0, attr=0, idx=0.
- attr byte: bit0 exec, bit1 cached, bit2 shared, bit3 non-idempotent, bit7 lock (see Configuration), bits 6:4 read as 0.
- Config access: always accepted. The response appears the next cycle, with cfg_rvalid_o high for exactly one cycle.
- An access is an error if any of the following holds: cfg_idx_i ≥ NrRules, field = 3, or a write hits a locked rule. An error returns rdata=0, err=1 and leaves state unchanged.
- Reads return base or length zero-extended, or attr in bits 7:0.
- A committed write updates the rule at the clock edge. pma_changed_o pulses in the cycle after that edge, together with cfg_rvalid_o.

## Timing
- Reset values:
  - Rules load RstBase, RstLength and RstAttr.
  - rsp_valid_o=0, rsp_attr_o=0, rsp_hit_o=0, rsp_idx_o=0.
  - cfg_rvalid_o=0, cfg_rdata_o=0, cfg_err_o=0, pma_changed_o=0.
- Lookup latency is 1 cycle. Match is evaluated on the request-cycle rule contents and registered on lkp_valid_i && lkp_ready_o.
- lkp_ready_o = !rsp_valid_o || rsp_ready_i, which gives full throughput.
- Backpressure: the response holds stable while rsp_valid_o && !rsp_ready_i.
- rsp_valid_o drops the cycle after consumption if no new lookup is accepted.
- Simultaneous config write and lookup in the same cycle: the lookup sees the old value. The new value is visible to lookups starting the next cycle.
- Reset asserted mid-operation clears in-flight responses and reverts all rules to reset values immediately (asynchronous).

## Configuration
- PMA_TABLE_LOCK_EN:
  - Defined: attr bit7 is a sticky lock. Once it is set, writes to any field of that rule (including attr) return err=1 until reset; lock bits are settable from RstAttr.
  - Undefined: bit7 is not stored, reads 0, and is never a source of errors.

## Test plan
- Reset with RstBase[0]=0x8000_0000, RstLength[0]=0x4000_0000, RstAttr[0]=0x07; lookup 0x8000_1000 → hit=1, idx=0, attr=0x7 one cycle later; lookup 0xC000_0000 → hit=0, attr=0.
- Overlap priority: rule1 = 0x1_0000 + 0x10000 with attr 0x1, rule3 = 0x0 + 0x100000 with attr 0x8; lookup 0x1_0004 → idx=1, attr=0x1.
- Hold rsp_ready_i=0 for 3 cycles with lkp_valid_i=1 → lkp_ready_o=0 and the response stays stable; release → back-to-back responses, one per cycle.
- Write length of rule 2 in the same cycle as a lookup into the new range → that lookup misses, the next one hits; pma_changed_o pulses once.
- Invalid access: cfg_idx_i=NrRules, or field=3 → err=1, rdata=0, no pma_changed_o.
- With PMA_TABLE_LOCK_EN: write attr 0x81 to rule 0, then write base → err=1 and base unchanged. Without the macro, the same sequence succeeds and attr reads 0x01.

Source files
------------

// File: rtl/cva6_pma_table.sv
// Runtime-programmable physical-memory-attribute table.
//
// Each rule slot holds a base, a length and an attribute byte. Lookups are
// classified against the live table and the result is registered, giving one
// cycle of latency with a valid/ready handshake on both sides. A small register
// port reads and writes individual rule fields; every committed write produces
// a one-cycle pma_changed_o pulse so that TLBs and cache policy can be flushed.
//
// Optional build macro: PMA_TABLE_LOCK_EN
//   defined   - attr bit 7 is a sticky per-rule lock; a locked rule rejects
//               all writes until reset.
//   undefined - attr bit 7 is not stored and always reads 0.
//
// Attribute byte layout:
//   bit0 exec | bit1 cached | bit2 shared | bit3 non-idempotent | bit7 lock
//   bits 6:4 are not stored and read as 0.

module cva6_pma_table #(
  parameter int unsigned NrRules   = 8,
  parameter int unsigned AddrWidth = 64,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstBase   = '0,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstLength = '0,
  parameter logic [NrRules-1:0][7:0]           RstAttr   = '0,
  parameter int unsigned IdxW = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // lookup request
  input  logic                 lkp_valid_i,
  output logic                 lkp_ready_o,
  input  logic [AddrWidth-1:0] lkp_addr_i,
  // lookup response
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [3:0]           rsp_attr_o,
  output logic                 rsp_hit_o,
  output logic [IdxW-1:0]      rsp_idx_o,
  // configuration port
  input  logic                 cfg_valid_i,
  input  logic                 cfg_we_i,
  input  logic [3:0]           cfg_idx_i,
  input  logic [1:0]           cfg_field_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_rvalid_o,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_err_o,
  output logic                 pma_changed_o
);

`ifdef PMA_TABLE_LOCK_EN
  localparam logic [7:0] AttrMask = 8'h8F;
`else
  localparam logic [7:0] AttrMask = 8'h0F;
`endif

  localparam logic [1:0] FieldBase = 2'd0;
  localparam logic [1:0] FieldLen  = 2'd1;
  localparam logic [1:0] FieldAttr = 2'd2;
  localparam logic [1:0] FieldRsvd = 2'd3;

  localparam logic [4:0] NrRulesW = 5'(NrRules);

  // ---------------------------------------------------------------------------
  // Rule storage
  // ---------------------------------------------------------------------------
  logic [AddrWidth-1:0] base_q [NrRules];
  logic [AddrWidth-1:0] len_q  [NrRules];
  logic [7:0]           attr_q [NrRules];

  // ---------------------------------------------------------------------------
  // Configuration decode
  // ---------------------------------------------------------------------------
  logic [IdxW-1:0] cfg_sel;
  logic            cfg_idx_bad;
  logic            sel_locked;
  logic            cfg_err;
  logic            cfg_commit;

  assign cfg_sel     = cfg_idx_i[IdxW-1:0];
  assign cfg_idx_bad = ({1'b0, cfg_idx_i} >= NrRulesW);

`ifdef PMA_TABLE_LOCK_EN
  assign sel_locked = attr_q[cfg_sel][7];
`else
  assign sel_locked = 1'b0;
`endif

  // An out-of-range index short-circuits the error before the lock bit of a
  // non-existent slot could matter.
  assign cfg_err    = cfg_idx_bad || (cfg_field_i == FieldRsvd) ||
                      (cfg_we_i && sel_locked);
  assign cfg_commit = cfg_valid_i && cfg_we_i && !cfg_err;

  logic [AddrWidth-1:0] cfg_rdata_d;

  // Read mux: a valid, error-free read returns the selected field, all else 0.
  always_comb begin
    cfg_rdata_d = '0;
    if (cfg_valid_i && !cfg_we_i && !cfg_err) begin
      unique case (cfg_field_i)
        FieldBase: cfg_rdata_d = base_q[cfg_sel];
        FieldLen:  cfg_rdata_d = len_q[cfg_sel];
        FieldAttr: cfg_rdata_d = {{(AddrWidth-8){1'b0}}, attr_q[cfg_sel]};
        default:   cfg_rdata_d = '0;
      endcase
    end
  end

  // Rule table: reset image from parameters, updated by committed writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrRules; i++) begin
        base_q[i] <= RstBase[i];
        len_q[i]  <= RstLength[i];
        attr_q[i] <= RstAttr[i] & AttrMask;
      end
    end else if (cfg_commit) begin
      unique case (cfg_field_i)
        FieldBase: base_q[cfg_sel] <= cfg_wdata_i;
        FieldLen:  len_q[cfg_sel]  <= cfg_wdata_i;
        FieldAttr: attr_q[cfg_sel] <= cfg_wdata_i[7:0] & AttrMask;
        default:   ;
      endcase
    end
  end

  logic                 cfg_rvalid_q;
  logic [AddrWidth-1:0] cfg_rdata_q;
  logic                 cfg_err_q;
  logic                 pma_changed_q;

  // Config response: one-cycle strobe with data/error, plus the change pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_rvalid_q  <= 1'b0;
      cfg_rdata_q   <= '0;
      cfg_err_q     <= 1'b0;
      pma_changed_q <= 1'b0;
    end else begin
      cfg_rvalid_q  <= cfg_valid_i;
      cfg_rdata_q   <= cfg_rdata_d;
      cfg_err_q     <= cfg_valid_i && cfg_err;
      pma_changed_q <= cfg_commit;
    end
  end

  assign cfg_rvalid_o  = cfg_rvalid_q;
  assign cfg_rdata_o   = cfg_rdata_q;
  assign cfg_err_o     = cfg_err_q;
  assign pma_changed_o = pma_changed_q;

  // ---------------------------------------------------------------------------
  // Address match
  // ---------------------------------------------------------------------------
  // The end address is kept one bit wider so a region reaching the top of the
  // address space carries out instead of wrapping back to zero.
  logic [NrRules-1:0] rule_match;

  for (genvar g = 0; g < NrRules; g++) begin : g_match
    logic [AddrWidth:0] limit;
    assign limit         = {1'b0, base_q[g]} + {1'b0, len_q[g]};
    assign rule_match[g] = (len_q[g] != '0) &&
                           (lkp_addr_i >= base_q[g]) &&
                           ({1'b0, lkp_addr_i} < limit);
  end

  logic            match_hit;
  logic [IdxW-1:0] match_idx;
  logic [3:0]      match_attr;

  // Priority select: iterate high to low so the lowest matching index wins.
  always_comb begin
    match_hit  = 1'b0;
    match_idx  = '0;
    match_attr = '0;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (rule_match[i]) begin
        match_hit  = 1'b1;
        match_idx  = IdxW'(i);
        match_attr = attr_q[i][3:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup response register
  // ---------------------------------------------------------------------------
  logic            rsp_valid_q;
  logic [3:0]      rsp_attr_q;
  logic            rsp_hit_q;
  logic [IdxW-1:0] rsp_idx_q;
  logic            lkp_accept;

  assign lkp_ready_o = !rsp_valid_q || rsp_ready_i;
  assign lkp_accept  = lkp_valid_i && lkp_ready_o;

  // Capture the match on acceptance; hold while stalled; drop when drained.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_attr_q  <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
    end else if (lkp_accept) begin
      rsp_valid_q <= 1'b1;
      rsp_attr_q  <= match_attr;
      rsp_hit_q   <= match_hit;
      rsp_idx_q   <= match_idx;
    end else if (rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_attr_o  = rsp_attr_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_idx_o   = rsp_idx_q;

endmodule

// File: tb/tb_cva6_pma_table.sv
// Bench for cva6_pma_table: directed scenarios followed by randomized config
// traffic and a randomized lookup stream, all checked against a table model.

module tb_cva6_pma_table;

  localparam int N  = 8;
  localparam int AW = 64;

  localparam logic [N-1:0][AW-1:0] RB = {{(N-1){64'h0}}, 64'h8000_0000};
  localparam logic [N-1:0][AW-1:0] RL = {{(N-1){64'h0}}, 64'h4000_0000};
  localparam logic [N-1:0][7:0]    RA = {{(N-1){8'h00}}, 8'h07};

`ifdef PMA_TABLE_LOCK_EN
  localparam bit         LOCK = 1'b1;
  localparam logic [7:0] KEEP = 8'h8F;
`else
  localparam bit         LOCK = 1'b0;
  localparam logic [7:0] KEEP = 8'h0F;
`endif

  logic          clk, rst_n;
  logic          lkp_valid, lkp_ready, rsp_valid, rsp_ready, rsp_hit;
  logic [AW-1:0] lkp_addr;
  logic [3:0]    rsp_attr;
  logic [2:0]    rsp_idx;
  logic          cfg_valid, cfg_we, cfg_rvalid, cfg_err, pma_changed;
  logic [3:0]    cfg_idx;
  logic [1:0]    cfg_field;
  logic [AW-1:0] cfg_wdata, cfg_rdata;

  cva6_pma_table #(
    .NrRules(N), .AddrWidth(AW), .RstBase(RB), .RstLength(RL), .RstAttr(RA)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lkp_valid_i(lkp_valid), .lkp_ready_o(lkp_ready), .lkp_addr_i(lkp_addr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_attr_o(rsp_attr),
    .rsp_hit_o(rsp_hit), .rsp_idx_o(rsp_idx),
    .cfg_valid_i(cfg_valid), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
    .cfg_field_i(cfg_field), .cfg_wdata_i(cfg_wdata), .cfg_rvalid_o(cfg_rvalid),
    .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err), .pma_changed_o(pma_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model: plain table of rules ----------------
  logic [63:0] m_base [N];
  logic [63:0] m_len  [N];
  logic [7:0]  m_attr [N];

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_base[i] = RB[i];
      m_len[i]  = RL[i];
      m_attr[i] = RA[i] & KEEP;
    end
  endfunction

  function automatic bit m_err(bit we, int idx, int field);
    if (idx >= N || field == 3) return 1'b1;
    if (we && LOCK && m_attr[idx][7]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] m_read(int idx, int field);
    case (field)
      0:       return m_base[idx];
      1:       return m_len[idx];
      2:       return {56'h0, m_attr[idx]};
      default: return 64'h0;
    endcase
  endfunction

  function automatic void m_write(int idx, int field, logic [63:0] wd);
    case (field)
      0:       m_base[idx] = wd;
      1:       m_len[idx]  = wd;
      2:       m_attr[idx] = wd[7:0] & KEEP;
      default: ;
    endcase
  endfunction

  // Offset form (addr - base < len) is exact for a region that ends at the
  // top of the address space, with no need for a wide sum.
  task automatic m_lookup(input logic [63:0] a, output bit hit, output int idx,
                          output logic [3:0] attr);
    hit = 1'b0; idx = 0; attr = 4'h0;
    for (int i = 0; i < N; i++) begin
      if (!hit && m_len[i] != 0 && a >= m_base[i] && (a - m_base[i]) < m_len[i]) begin
        hit = 1'b1; idx = i; attr = m_attr[i][3:0];
      end
    end
  endtask

  // ---------------- stimulus helpers (entered and left at posedge+1) ------
  task automatic do_cfg(input bit we, input int idx, input int field,
                        input logic [63:0] wd, input string tag);
    bit          e;
    logic [63:0] rd;
    e  = m_err(we, idx, field);
    rd = (!e && !we) ? m_read(idx, field) : 64'h0;
    cfg_valid = 1'b1; cfg_we = we; cfg_idx = idx[3:0]; cfg_field = field[1:0];
    cfg_wdata = wd;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    chk({tag, ".rvalid"}, 64'(cfg_rvalid), 64'h1);
    chk({tag, ".err"}, 64'(cfg_err), 64'(e));
    chk({tag, ".changed"}, 64'(pma_changed), 64'(we && !e));
    if (!we || e) chk({tag, ".rdata"}, cfg_rdata, rd);
    if (we && !e) m_write(idx, field, wd);
  endtask

  task automatic do_lookup(input logic [63:0] a, input string tag);
    bit         eh;
    int         ei;
    logic [3:0] ea;
    m_lookup(a, eh, ei, ea);
    lkp_valid = 1'b1; lkp_addr = a; rsp_ready = 1'b1;
    @(posedge clk); #1;
    lkp_valid = 1'b0;
    chk({tag, ".valid"}, 64'(rsp_valid), 64'h1);
    chk({tag, ".hit"}, 64'(rsp_hit), 64'(eh));
    chk({tag, ".idx"}, 64'(rsp_idx), 64'(ei));
    chk({tag, ".attr"}, 64'(rsp_attr), 64'(ea));
    @(posedge clk); #1;
    chk({tag, ".drop"}, 64'(rsp_valid), 64'h0);
  endtask

  // ---------------- main sequence ----------------
  bit          eh, ah, bh, ch, ev;
  int          ei, ai, bi, ci;
  logic [3:0]  ea, aa, ba, ca;
  logic [63:0] a, wd;
  int          ridx, rfld, j;
  bit          rwe, lv, rr;

  initial begin
    rst_n = 1'b0; lkp_valid = 1'b0; lkp_addr = '0; rsp_ready = 1'b1;
    cfg_valid = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_field = '0; cfg_wdata = '0;
    m_reset();
    #3;
    chk("rst.rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst.rsp_hit", 64'(rsp_hit), 64'h0);
    chk("rst.rsp_idx", 64'(rsp_idx), 64'h0);
    chk("rst.rsp_attr", 64'(rsp_attr), 64'h0);
    chk("rst.cfg_rvalid", 64'(cfg_rvalid), 64'h0);
    chk("rst.cfg_rdata", cfg_rdata, 64'h0);
    chk("rst.cfg_err", 64'(cfg_err), 64'h0);
    chk("rst.changed", 64'(pma_changed), 64'h0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle.cfg_rvalid", 64'(cfg_rvalid), 64'h0);

    // reset image readback and lookups around rule 0
    do_cfg(0, 0, 0, 0, "rd.base0");
    do_cfg(0, 0, 1, 0, "rd.len0");
    do_cfg(0, 0, 2, 0, "rd.attr0");
    do_lookup(64'h8000_1000, "lk.in0");
    do_lookup(64'hC000_0000, "lk.end0");
    do_lookup(64'hBFFF_FFFF, "lk.last0");
    do_lookup(64'h7FFF_FFFF, "lk.below0");

    // overlapping rules: lowest index wins
    do_cfg(1, 1, 0, 64'h1_0000, "wr.base1");
    do_cfg(1, 1, 1, 64'h1_0000, "wr.len1");
    do_cfg(1, 1, 2, 64'h1, "wr.attr1");
    do_cfg(1, 3, 0, 64'h0, "wr.base3");
    do_cfg(1, 3, 1, 64'h10_0000, "wr.len3");
    do_cfg(1, 3, 2, 64'h8, "wr.attr3");
    do_lookup(64'h1_0004, "lk.prio");
    do_lookup(64'h2_0000, "lk.end1");

    // backpressure: first lookup taken, then stall three cycles
    m_lookup(64'h8000_2000, ah, ai, aa);
    m_lookup(64'h1_0008, bh, bi, ba);
    m_lookup(64'hC000_0000, ch, ci, ca);
    lkp_valid = 1'b1; lkp_addr = 64'h8000_2000; rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("bp.first.valid", 64'(rsp_valid), 64'h1);
    lkp_addr = 64'h1_0008;
    for (int k = 0; k < 3; k++) begin
      chk("bp.ready_low", 64'(lkp_ready), 64'h0);
      @(posedge clk); #1;
      chk("bp.hold.valid", 64'(rsp_valid), 64'h1);
      chk("bp.hold.hit", 64'(rsp_hit), 64'(ah));
      chk("bp.hold.idx", 64'(rsp_idx), 64'(ai));
      chk("bp.hold.attr", 64'(rsp_attr), 64'(aa));
    end
    rsp_ready = 1'b1;
    #1 chk("bp.ready_high", 64'(lkp_ready), 64'h1);
    @(posedge clk); #1;
    chk("bp.b.valid", 64'(rsp_valid), 64'h1);
    chk("bp.b.idx", 64'(rsp_idx), 64'(bi));
    chk("bp.b.attr", 64'(rsp_attr), 64'(ba));
    lkp_addr = 64'hC000_0000;
    @(posedge clk); #1;
    chk("bp.c.valid", 64'(rsp_valid), 64'h1);
    chk("bp.c.hit", 64'(rsp_hit), 64'(ch));
    lkp_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp.drain", 64'(rsp_valid), 64'h0);

    // write racing a lookup: lookup sees the old table
    do_cfg(1, 2, 0, 64'h2000_0000, "wr.base2");
    m_lookup(64'h2000_0010, eh, ei, ea);
    lkp_valid = 1'b1; lkp_addr = 64'h2000_0010;
    cfg_valid = 1'b1; cfg_we = 1'b1; cfg_idx = 4'd2; cfg_field = 2'd1; cfg_wdata = 64'h1000;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    m_write(2, 1, 64'h1000);
    chk("race.hit_old", 64'(rsp_hit), 64'(eh));
    chk("race.changed", 64'(pma_changed), 64'h1);
    chk("race.rvalid", 64'(cfg_rvalid), 64'h1);
    m_lookup(64'h2000_0010, eh, ei, ea);
    @(posedge clk); #1;
    lkp_valid = 1'b0;
    chk("race.changed_once", 64'(pma_changed), 64'h0);
    chk("race.rvalid_once", 64'(cfg_rvalid), 64'h0);
    chk("race.hit_new", 64'(rsp_hit), 64'(eh));
    chk("race.idx_new", 64'(rsp_idx), 64'(ei));
    @(posedge clk); #1;

    // invalid accesses
    do_cfg(0, N, 0, 0, "err.idx_rd");
    do_cfg(1, 9, 1, 64'h55, "err.idx_wr");
    do_cfg(1, 2, 3, 64'h55, "err.field_wr");
    do_cfg(0, 2, 3, 0, "err.field_rd");
    do_cfg(0, 2, 1, 0, "err.unchanged");

    // region reaching the top of the address space must not wrap
    do_cfg(1, 3, 1, 64'h0, "wr.len3_off");
    do_cfg(1, 5, 0, 64'hFFFF_FFFF_FFFF_F000, "wr.base5");
    do_cfg(1, 5, 1, 64'h2000, "wr.len5");
    do_cfg(1, 5, 2, 64'h4, "wr.attr5");
    do_lookup(64'hFFFF_FFFF_FFFF_FFF0, "lk.top");
    do_lookup(64'h500, "lk.nowrap");

    // randomized config traffic
    for (int k = 0; k < 60; k++) begin
      ridx = $urandom_range(0, 9);
      rfld = $urandom_range(0, 3);
      rwe  = ($urandom_range(0, 2) != 0);
      case (rfld)
        0:       wd = 64'($urandom_range(0, 32'h4_0000));
        1:       wd = 64'($urandom_range(0, 32'h8000));
        default: wd = {$urandom, $urandom} & ~64'h80;
      endcase
      do_cfg(rwe, ridx, rfld, wd, "rnd.cfg");
    end

    // randomized lookup stream with random backpressure
    ev = 1'b0;
    for (int k = 0; k < 400; k++) begin
      lv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 2) != 0);
      j  = $urandom_range(0, N - 1);
      a  = m_base[j] + 64'($urandom_range(0, 32'h9000)) - 64'h100;
      lkp_valid = lv; lkp_addr = a; rsp_ready = rr;
      #1 chk("rnd.lkp_ready", 64'(lkp_ready), 64'(!ev || rr));
      @(posedge clk);
      if (lv && (!ev || rr)) begin
        m_lookup(a, eh, ei, ea);
        ev = 1'b1;
      end else if (rr) begin
        ev = 1'b0;
      end
      #1;
      chk("rnd.valid", 64'(rsp_valid), 64'(ev));
      if (ev) begin
        chk("rnd.hit", 64'(rsp_hit), 64'(eh));
        chk("rnd.idx", 64'(rsp_idx), 64'(ei));
        chk("rnd.attr", 64'(rsp_attr), 64'(ea));
      end
    end
    lkp_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;

    // lock behaviour (model follows the build option)
    do_cfg(1, 0, 2, 64'h81, "lock.set");
    do_cfg(1, 0, 0, 64'h1234, "lock.wr_base");
    do_cfg(0, 0, 0, 0, "lock.rd_base");
    do_cfg(0, 0, 2, 0, "lock.rd_attr");
    do_cfg(1, 0, 2, 64'h02, "lock.wr_attr");

    // asynchronous reset mid-operation
    lkp_valid = 1'b1; lkp_addr = 64'h1_0004; rsp_ready = 1'b0;
    @(posedge clk); #1;
    lkp_valid = 1'b0;
    chk("arst.pre_valid", 64'(rsp_valid), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", 64'(rsp_valid), 64'h0);
    chk("arst.hit", 64'(rsp_hit), 64'h0);
    chk("arst.attr", 64'(rsp_attr), 64'h0);
    m_reset();
    #2 rst_n = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    do_cfg(0, 1, 1, 0, "arst.len1");
    do_cfg(0, 0, 2, 0, "arst.attr0");
    do_cfg(1, 0, 0, 64'h9000_0000, "arst.unlocked");
    do_lookup(64'h9000_0000, "arst.lk");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
